// File: rtl/hsrx_multilane_fsm.sv
// HS receive controller for 1..4 D-PHY lanes: settle -> zero -> sync -> data sequencing with per-lane sync detect.
// Latency: every output is registered; a DATA ByteStrobe at cycle N shows on HSFSM_Bytes/RxValidHS at N+1.
// Backpressure: none; the deserializer strobe is accepted unconditionally and the PPI side must take RxValidHS pulses.
// Ports: RxDDRClkHS/RxRst (sync, active high); HSRX_EN, Zero_Detected, ByteStrobe, RxByte_HS in;
//        dueledge_ff_en, deserializer_en, HSFSM_Bytes, RxValidHS, RxActiveHS, RxSyncHS,
//        ErrSotHS, ErrSotSyncHS, RxState out.
module hsrx_multilane_fsm #(
    parameter int         NUM_LANES     = 2,
    parameter logic [7:0] SYNC_PATTERN  = 8'hB8,
    parameter int         SETTLE_CYCLES = 6,
    parameter int         SYNC_TIMEOUT  = 32,
    parameter int         SKEW_MAX      = 1,
    parameter int         SYNC_ERR_TOL  = 1
) (
    input  logic                     RxDDRClkHS,
    input  logic                     RxRst,
    input  logic                     HSRX_EN,
    input  logic [NUM_LANES-1:0]     Zero_Detected,
    input  logic                     ByteStrobe,
    input  logic [8*NUM_LANES-1:0]   RxByte_HS,
    output logic                     dueledge_ff_en,
    output logic                     deserializer_en,
    output logic [8*NUM_LANES-1:0]   HSFSM_Bytes,
    output logic [NUM_LANES-1:0]     RxValidHS,
    output logic                     RxActiveHS,
    output logic                     RxSyncHS,
    output logic [NUM_LANES-1:0]     ErrSotHS,
    output logic                     ErrSotSyncHS,
    output logic [2:0]               RxState
);

    typedef enum logic [2:0] {
        ST_STOP   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_TERM   = 3'd2,
        ST_SYNC   = 3'd3,
        ST_DATA   = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TMR_W = $clog2(SYNC_TIMEOUT + 1);
    // Holds SKEW_MAX+1 so the first over-limit strobe is representable.
    localparam int SKW_W = $clog2(SKEW_MAX + 2);

    localparam logic [SET_W-1:0] SET_LIM  = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMO_LIM  = TMR_W'(SYNC_TIMEOUT - 1);
    localparam logic [SKW_W-1:0] SKEW_LIM = SKW_W'(SKEW_MAX);
    localparam bit               TOL_EN   = (SYNC_ERR_TOL != 0);
    localparam logic [NUM_LANES-1:0] ALL_LANES = {NUM_LANES{1'b1}};

    state_t                   state_q;
    logic [SET_W-1:0]         settle_q;
    logic [TMR_W-1:0]         tmr_q;
    logic [SKW_W-1:0]         skew_q;
    logic [NUM_LANES-1:0]     synced_q;
    logic                     en_q;
    logic [8*NUM_LANES-1:0]   bytes_q;
    logic [NUM_LANES-1:0]     valid_q;
    logic                     active_q;
    logic                     sync_q;
    logic [NUM_LANES-1:0]     err_sot_q;
    logic                     err_sync_q;

    logic [7:0]               lane_diff;
    logic [NUM_LANES-1:0]     hit_exact;
    logic [NUM_LANES-1:0]     hit_one;
    logic [NUM_LANES-1:0]     strobe_hit;
    logic [NUM_LANES-1:0]     synced_d;
    logic [NUM_LANES-1:0]     sot_err_d;
    logic                     all_synced;
    logic                     skew_viol;
    logic                     sync_tmo;

    // Per-lane sync byte classification: exact match or single-bit error.
    always_comb begin
        lane_diff = 8'd0;
        hit_exact = '0;
        hit_one   = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_diff    = RxByte_HS[8*i +: 8] ^ SYNC_PATTERN;
            hit_exact[i] = (lane_diff == 8'd0);
            // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
            hit_one[i]   = (lane_diff != 8'd0) && ((lane_diff & (lane_diff - 8'd1)) == 8'd0);
        end
        strobe_hit = ByteStrobe ? (hit_exact | (TOL_EN ? hit_one : '0)) : '0;
        synced_d   = synced_q | strobe_hit;
        all_synced = (synced_d == ALL_LANES);
        // Only lanes syncing for the first time contribute a SoT error.
        sot_err_d  = strobe_hit & ~hit_exact & ~synced_q;
        // The strobe that would push the first-to-last lane gap past SKEW_MAX
        // fails even if it completes the lane set.
        skew_viol  = ByteStrobe && (|synced_q) && (skew_q >= SKEW_LIM);
        sync_tmo   = (tmr_q >= TMO_LIM);
    end

    always_ff @(posedge RxDDRClkHS) begin
        if (RxRst) begin
            state_q    <= ST_STOP;
            settle_q   <= '0;
            tmr_q      <= '0;
            skew_q     <= '0;
            synced_q   <= '0;
            en_q       <= 1'b0;
            bytes_q    <= '0;
            valid_q    <= '0;
            active_q   <= 1'b0;
            sync_q     <= 1'b0;
            err_sot_q  <= '0;
            err_sync_q <= 1'b0;
        end else begin
            sync_q  <= 1'b0;
            valid_q <= '0;
            // Enables follow the current state, so they lag state entry by one cycle.
            en_q    <= (state_q == ST_SETTLE) || (state_q == ST_TERM) ||
                       (state_q == ST_SYNC)   || (state_q == ST_DATA);

            if ((state_q != ST_STOP) && !HSRX_EN) begin
                // Loss of enable beats everything, including a same-cycle sync.
                state_q  <= ST_STOP;
                active_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_STOP: begin
                        if (HSRX_EN) begin
                            state_q    <= ST_SETTLE;
                            settle_q   <= '0;
                            err_sot_q  <= '0;
                            err_sync_q <= 1'b0;
                        end
                    end
                    ST_SETTLE: begin
                        if (settle_q >= SET_LIM) begin
                            state_q <= ST_TERM;
                        end else begin
                            settle_q <= settle_q + 1'b1;
                        end
                    end
                    ST_TERM: begin
                        if (&Zero_Detected) begin
                            state_q  <= ST_SYNC;
                            tmr_q    <= '0;
                            skew_q   <= '0;
                            synced_q <= '0;
                        end
                    end
                    ST_SYNC: begin
                        synced_q  <= synced_d;
                        err_sot_q <= err_sot_q | sot_err_d;
                        if (tmr_q < TMO_LIM) begin
                            tmr_q <= tmr_q + 1'b1;
                        end
                        if (ByteStrobe && (|synced_q) && (skew_q < SKEW_LIM)) begin
                            skew_q <= skew_q + 1'b1;
                        end
                        if (skew_viol) begin
                            state_q    <= ST_ERR;
                            err_sync_q <= 1'b1;
                        end else if (all_synced) begin
                            state_q  <= ST_DATA;
                            sync_q   <= 1'b1;
                            active_q <= 1'b1;
                        end else if (sync_tmo) begin
                            state_q    <= ST_ERR;
                            err_sync_q <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (ByteStrobe) begin
                            bytes_q <= RxByte_HS;
                            valid_q <= ALL_LANES;
                        end
                    end
                    ST_ERR: begin
                        active_q <= 1'b0;
                    end
                    default: begin
                        state_q  <= ST_STOP;
                        active_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign dueledge_ff_en  = en_q;
    assign deserializer_en = en_q;
    assign HSFSM_Bytes     = bytes_q;
    assign RxValidHS       = valid_q;
    assign RxActiveHS      = active_q;
    assign RxSyncHS        = sync_q;
    assign ErrSotHS        = err_sot_q;
    assign ErrSotSyncHS    = err_sync_q;
    assign RxState         = state_q;

endmodule
